rv32_debug_mem_master: RTL

- Initiator for the core's debug memory ports (InstRAM/DataRAM second port: A2, WD2, WE2, RD2).
- Accepts word-burst load and dump commands from a host-side controller (UART bridge or testbench) over valid/ready streams.
- Sequences them onto the debug port, e.g. preloading programs into InstRAM and dumping DataRAM after a run.
- Sits outside the core, beside the top-level FPGA wrapper.

---
 rtl/rv32_debug_mem_master_if.sv | 68 ++++++
 rtl/rv32_debug_mem_master.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/rv32_debug_mem_master_if.sv
// Bundle of host-side streams (command, write data, read data, status) and the
// two debug RAM ports driven by rv32_debug_mem_master.
//   cmd_*        : command stream (write/dump, target RAM, byte address, word count)
//   wd_*         : write-data stream into the master
//   rd_*         : read-data stream out of the master
//   busy, done   : command in progress / one-cycle completion pulse
//   Dbg_DataRAM_*: DataRAM second port (A2, WD2, WE2 out; RD2 in)
//   Dbg_InstRAM_*: InstRAM second port (A2, WD2, WE2 out; RD2 in)
// Modport master is the debug master's view, slave is the host/RAM view.
interface rv32_debug_mem_master_if #(
    parameter int unsigned LEN_W = 16
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic              cmd_target;
    logic [31:0]       cmd_addr;
    logic [LEN_W-1:0]  cmd_len;

    logic              wd_valid;
    logic              wd_ready;
    logic [31:0]       wd_data;

    logic              rd_valid;
    logic              rd_ready;
    logic [31:0]       rd_data;

    logic              busy;
    logic              done;

    logic [31:0]       Dbg_DataRAM_A2;
    logic [31:0]       Dbg_DataRAM_WD2;
    logic [3:0]        Dbg_DataRAM_WE2;
    logic [31:0]       Dbg_DataRAM_RD2;

    logic [31:0]       Dbg_InstRAM_A2;
    logic [31:0]       Dbg_InstRAM_WD2;
    logic [3:0]        Dbg_InstRAM_WE2;
    logic [31:0]       Dbg_InstRAM_RD2;

    modport master (
        input  cmd_valid, cmd_write, cmd_target, cmd_addr, cmd_len,
        output cmd_ready,
        input  wd_valid, wd_data,
        output wd_ready,
        output rd_valid, rd_data,
        input  rd_ready,
        output busy, done,
        output Dbg_DataRAM_A2, Dbg_DataRAM_WD2, Dbg_DataRAM_WE2,
        input  Dbg_DataRAM_RD2,
        output Dbg_InstRAM_A2, Dbg_InstRAM_WD2, Dbg_InstRAM_WE2,
        input  Dbg_InstRAM_RD2
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_target, cmd_addr, cmd_len,
        input  cmd_ready,
        output wd_valid, wd_data,
        input  wd_ready,
        input  rd_valid, rd_data,
        output rd_ready,
        input  busy, done,
        input  Dbg_DataRAM_A2, Dbg_DataRAM_WD2, Dbg_DataRAM_WE2,
        output Dbg_DataRAM_RD2,
        input  Dbg_InstRAM_A2, Dbg_InstRAM_WD2, Dbg_InstRAM_WE2,
        output Dbg_InstRAM_RD2
    );
endinterface

// File: rtl/rv32_debug_mem_master.sv
// Debug memory master: turns host word-burst load/dump commands into accesses
// on the InstRAM/DataRAM debug ports (A2/WD2/WE2/RD2).
//   CPU_CLK : clock, rising edge
//   CPU_RST : synchronous active-high reset
//   bus     : rv32_debug_mem_master_if.master (command, write-data and
//             read-data streams, busy/done status, both debug RAM ports)
// All outputs are registered.
module rv32_debug_mem_master #(
    parameter int unsigned LEN_W  = 16,
    parameter int unsigned RD_LAT = 1
) (
    input  logic                         CPU_CLK,
    input  logic                         CPU_RST,
    rv32_debug_mem_master_if.master      bus
);

    localparam int unsigned WAIT_W = 1;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_WRITE   = 3'd1;
    localparam logic [2:0] S_RD_ADDR = 3'd2;
    localparam logic [2:0] S_RD_WAIT = 3'd3;
    localparam logic [2:0] S_RD_OUT  = 3'd4;
    localparam logic [2:0] S_FIN     = 3'd5;

    logic [2:0]        state_q,     state_d;
    logic              target_q,    target_d;
    logic [31:0]       addr_q,      addr_d;
    logic [LEN_W-1:0]  cnt_q,       cnt_d;
    logic [WAIT_W-1:0] wait_q,      wait_d;
    logic              cmd_ready_q, cmd_ready_d;
    logic              wd_ready_q,  wd_ready_d;
    logic              rd_valid_q,  rd_valid_d;
    logic [31:0]       rd_data_q,   rd_data_d;
    logic              busy_q,      busy_d;
    logic              done_q,      done_d;
    logic [31:0]       d_a2_q,      d_a2_d;
    logic [31:0]       d_wd2_q,     d_wd2_d;
    logic [3:0]        d_we2_q,     d_we2_d;
    logic [31:0]       i_a2_q,      i_a2_d;
    logic [31:0]       i_wd2_q,     i_wd2_d;
    logic [3:0]        i_we2_q,     i_we2_d;

    logic              cmd_hs, wd_hs, rd_hs, last_word;
    logic [31:0]       cmd_addr_al, addr_nxt, rd2_sel;

    // Next-state and registered-output logic
    always_comb begin
        state_d     = state_q;
        target_d    = target_q;
        addr_d      = addr_q;
        cnt_d       = cnt_q;
        wait_d      = wait_q;
        cmd_ready_d = cmd_ready_q;
        wd_ready_d  = wd_ready_q;
        rd_valid_d  = rd_valid_q;
        rd_data_d   = rd_data_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        d_a2_d      = d_a2_q;
        d_wd2_d     = d_wd2_q;
        d_we2_d     = 4'h0;
        i_a2_d      = i_a2_q;
        i_wd2_d     = i_wd2_q;
        i_we2_d     = 4'h0;

        cmd_hs      = bus.cmd_valid && cmd_ready_q;
        wd_hs       = bus.wd_valid && wd_ready_q;
        rd_hs       = rd_valid_q && bus.rd_ready;
        cmd_addr_al = bus.cmd_addr & ~32'h3;
        addr_nxt    = addr_q + 32'd4;
        last_word   = (cnt_q == LEN_W'(1));
        rd2_sel     = target_q ? bus.Dbg_InstRAM_RD2 : bus.Dbg_DataRAM_RD2;

        case (state_q)
            S_IDLE: begin
                cmd_ready_d = 1'b1;
                busy_d      = 1'b0;
                if (cmd_hs) begin
                    cmd_ready_d = 1'b0;
                    busy_d      = 1'b1;
                    target_d    = bus.cmd_target;
                    addr_d      = cmd_addr_al;
                    cnt_d       = bus.cmd_len;
                    if (bus.cmd_len == LEN_W'(0)) begin
                        state_d = S_FIN;
                    end else if (bus.cmd_write) begin
                        state_d    = S_WRITE;
                        wd_ready_d = 1'b1;
                    end else begin
                        // Present the first read address already in RD_ADDR
                        state_d = S_RD_ADDR;
                        if (bus.cmd_target) i_a2_d = cmd_addr_al;
                        else                d_a2_d = cmd_addr_al;
                    end
                end
            end

            S_WRITE: begin
                if (wd_hs) begin
                    if (target_q) begin
                        i_a2_d  = addr_q;
                        i_wd2_d = bus.wd_data;
                        i_we2_d = 4'hF;
                    end else begin
                        d_a2_d  = addr_q;
                        d_wd2_d = bus.wd_data;
                        d_we2_d = 4'hF;
                    end
                    addr_d = addr_nxt;
                    cnt_d  = cnt_q - LEN_W'(1);
                    if (last_word) begin
                        state_d    = S_FIN;
                        wd_ready_d = 1'b0;
                    end
                end
            end

            S_RD_ADDR: begin
                state_d = S_RD_WAIT;
                wait_d  = WAIT_W'(RD_LAT - 1);
            end

            // A2 has been stable since RD_ADDR; RD2 is valid on the last wait cycle
            S_RD_WAIT: begin
                if (wait_q == WAIT_W'(0)) begin
                    rd_data_d  = rd2_sel;
                    rd_valid_d = 1'b1;
                    state_d    = S_RD_OUT;
                end else begin
                    wait_d = wait_q - WAIT_W'(1);
                end
            end

            S_RD_OUT: begin
                if (rd_hs) begin
                    rd_valid_d = 1'b0;
                    addr_d     = addr_nxt;
                    cnt_d      = cnt_q - LEN_W'(1);
                    if (last_word) begin
                        state_d = S_FIN;
                    end else begin
                        state_d = S_RD_ADDR;
                        if (target_q) i_a2_d = addr_nxt;
                        else          d_a2_d = addr_nxt;
                    end
                end
            end

            // cmd_ready stays low here so it rises the cycle after done
            S_FIN: begin
                done_d      = 1'b1;
                busy_d      = 1'b0;
                cmd_ready_d = 1'b0;
                state_d     = S_IDLE;
            end

            default: begin
                state_d     = S_IDLE;
                cmd_ready_d = 1'b1;
                wd_ready_d  = 1'b0;
                rd_valid_d  = 1'b0;
                busy_d      = 1'b0;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge CPU_CLK) begin
        if (CPU_RST) begin
            state_q     <= S_IDLE;
            target_q    <= 1'b0;
            addr_q      <= 32'h0;
            cnt_q       <= '0;
            wait_q      <= '0;
            cmd_ready_q <= 1'b1;
            wd_ready_q  <= 1'b0;
            rd_valid_q  <= 1'b0;
            rd_data_q   <= 32'h0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            d_a2_q      <= 32'h0;
            d_wd2_q     <= 32'h0;
            d_we2_q     <= 4'h0;
            i_a2_q      <= 32'h0;
            i_wd2_q     <= 32'h0;
            i_we2_q     <= 4'h0;
        end else begin
            state_q     <= state_d;
            target_q    <= target_d;
            addr_q      <= addr_d;
            cnt_q       <= cnt_d;
            wait_q      <= wait_d;
            cmd_ready_q <= cmd_ready_d;
            wd_ready_q  <= wd_ready_d;
            rd_valid_q  <= rd_valid_d;
            rd_data_q   <= rd_data_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            d_a2_q      <= d_a2_d;
            d_wd2_q     <= d_wd2_d;
            d_we2_q     <= d_we2_d;
            i_a2_q      <= i_a2_d;
            i_wd2_q     <= i_wd2_d;
            i_we2_q     <= i_we2_d;
        end
    end

    assign bus.cmd_ready       = cmd_ready_q;
    assign bus.wd_ready        = wd_ready_q;
    assign bus.rd_valid        = rd_valid_q;
    assign bus.rd_data         = rd_data_q;
    assign bus.busy            = busy_q;
    assign bus.done            = done_q;
    assign bus.Dbg_DataRAM_A2  = d_a2_q;
    assign bus.Dbg_DataRAM_WD2 = d_wd2_q;
    assign bus.Dbg_DataRAM_WE2 = d_we2_q;
    assign bus.Dbg_InstRAM_A2  = i_a2_q;
    assign bus.Dbg_InstRAM_WD2 = i_wd2_q;
    assign bus.Dbg_InstRAM_WE2 = i_we2_q;

endmodule
